// File: rtl/rob_commit_unit_pkg.sv
// Shared types for the reorder buffer slice.
// Entry status flags and the retire-readiness rule.
package rob_commit_unit_pkg;

  typedef struct packed {
    logic valid;
    logic done;
    logic spec;
  } ent_flags_t;

  function automatic logic ent_ready(ent_flags_t f);
    return f.valid & f.done & ~f.spec;
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Picks the oldest run of retire-ready entries in the head window.
// The mask is a prefix-AND, so the count equals its popcount.
module rob_retire_select
  import rob_commit_unit_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int PTR_W    = 4
) (
  input  ent_flags_t [COMMIT_W-1:0] win,
  input  logic [PTR_W:0]            count,
  output logic [COMMIT_W-1:0]       mask,
  output logic [2:0]                n_ret
);

  always_comb begin
    logic run;
    run   = 1'b1;
    mask  = '0;
    n_ret = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      run = run & ent_ready(win[k])
                & (count > (PTR_W+1)'(k));
      mask[k] = run;
      n_ret   = n_ret + {2'b00, run};
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Circular reorder buffer with in-order retirement
// into an internal architectural register file.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int COMMIT_W  = 2,
  parameter int ARCH_REGS = 32,
  parameter int REG_W     = 5,
  parameter int ISS_W     = 8,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [REG_W-1:0]              alloc_dest,
  input  logic [ISS_W-1:0]              alloc_iss_id,
  input  logic                          alloc_spec,
  output logic [PTR_W-1:0]              alloc_idx,
  input  logic                          cdb_valid,
  input  logic [PTR_W-1:0]              cdb_idx,
  input  logic [ISS_W-1:0]              cdb_iss_id,
  input  logic [DATA_W-1:0]             cdb_data,
  input  logic                          br_resolve,
  input  logic                          br_mispredict,
  output logic [COMMIT_W-1:0]           retire_valid,
  output logic [COMMIT_W*REG_W-1:0]     retire_dest,
  output logic [COMMIT_W*DATA_W-1:0]    retire_data,
  output logic [ARCH_REGS*DATA_W-1:0]   retired_regs_o,
  output logic [PTR_W:0]                count,
  output logic                          full,
  output logic                          empty
);

  logic [PTR_W:0]       head, tail, spec_start;
  logic                 spec_active;
  logic [DEPTH-1:0]     e_valid, e_done, e_spec;
  logic [REG_W-1:0]     e_dest [DEPTH];
  logic [ISS_W-1:0]     e_iss  [DEPTH];
  logic [DATA_W-1:0]    e_data [DEPTH];
  logic [DATA_W-1:0]    regs   [ARCH_REGS];

  logic                 flush, alloc_fire, cdb_hit;
  ent_flags_t [COMMIT_W-1:0] win;
  logic [PTR_W-1:0]     w_idx [COMMIT_W];
  logic [COMMIT_W-1:0]  ret_mask;
  logic [2:0]           n_ret;

  // Wrap bit in the MSB distinguishes full from empty.
  assign count = tail - head;
  assign empty = (head == tail);
  assign full  = (head[PTR_W-1:0] == tail[PTR_W-1:0])
              && (head[PTR_W] != tail[PTR_W]);

  assign flush       = br_resolve && br_mispredict && spec_active;
  assign alloc_ready = !full && !(br_resolve && br_mispredict);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail[PTR_W-1:0];

  assign cdb_hit = cdb_valid && e_valid[cdb_idx]
                && (e_iss[cdb_idx] == cdb_iss_id)
                && !(flush && e_spec[cdb_idx]);

  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      w_idx[k]      = head[PTR_W-1:0] + PTR_W'(k);
      win[k].valid  = e_valid[w_idx[k]];
      win[k].done   = e_done[w_idx[k]];
      win[k].spec   = e_spec[w_idx[k]];
    end
  end

  rob_retire_select #(
    .COMMIT_W (COMMIT_W),
    .PTR_W    (PTR_W)
  ) u_sel (
    .win   (win),
    .count (count),
    .mask  (ret_mask),
    .n_ret (n_ret)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      spec_start   <= '0;
      spec_active  <= 1'b0;
      e_valid      <= '0;
      e_done       <= '0;
      e_spec       <= '0;
      retire_valid <= '0;
      retire_dest  <= '0;
      retire_data  <= '0;
      for (int r = 0; r < ARCH_REGS; r++)
        regs[r] <= '0;
    end else begin
      if (br_resolve && !br_mispredict) begin
        e_spec      <= '0;
        spec_active <= 1'b0;
      end
      if (flush) begin
        e_valid     <= e_valid & ~e_spec;
        e_done      <= e_done & ~e_spec;
        e_spec      <= '0;
        tail        <= spec_start;
        spec_active <= 1'b0;
      end
      if (cdb_hit)
        e_done[cdb_idx] <= 1'b1;

      // Ascending slot order lets the younger write win.
      retire_valid <= ret_mask;
      for (int k = 0; k < COMMIT_W; k++) begin
        retire_dest[k*REG_W +: REG_W]    <= e_dest[w_idx[k]];
        retire_data[k*DATA_W +: DATA_W]  <= e_data[w_idx[k]];
        if (ret_mask[k]) begin
          e_valid[w_idx[k]] <= 1'b0;
          e_done[w_idx[k]]  <= 1'b0;
          if (e_dest[w_idx[k]] != '0)
            regs[e_dest[w_idx[k]]] <= e_data[w_idx[k]];
        end
      end
      head <= head + (PTR_W+1)'(n_ret);

      if (alloc_fire) begin
        e_valid[alloc_idx] <= 1'b1;
        e_done[alloc_idx]  <= 1'b0;
        e_spec[alloc_idx]  <= alloc_spec;
        tail               <= tail + (PTR_W+1)'(1);
        if (alloc_spec && (!spec_active || br_resolve)) begin
          spec_start  <= tail;
          spec_active <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      e_dest[alloc_idx] <= alloc_dest;
      e_iss[alloc_idx]  <= alloc_iss_id;
    end
    if (cdb_hit)
      e_data[cdb_idx] <= cdb_data;
  end

  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++)
      retired_regs_o[(ARCH_REGS-1-r)*DATA_W +: DATA_W] = regs[r];
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit.
// Scenario tasks with hand-computed expectations.
module tb_rob_commit_unit;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [4:0]  alloc_dest;
  logic [7:0]  alloc_iss_id;
  logic        alloc_spec;
  logic [3:0]  alloc_idx;
  logic        cdb_valid;
  logic [3:0]  cdb_idx;
  logic [7:0]  cdb_iss_id;
  logic [31:0] cdb_data;
  logic        br_resolve;
  logic        br_mispredict;
  logic [1:0]  retire_valid;
  logic [9:0]  retire_dest;
  logic [63:0] retire_data;
  logic [1023:0] retired_regs_o;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int n_chk;
  int n_fail;

  rob_commit_unit dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_dest     (alloc_dest),
    .alloc_iss_id   (alloc_iss_id),
    .alloc_spec     (alloc_spec),
    .alloc_idx      (alloc_idx),
    .cdb_valid      (cdb_valid),
    .cdb_idx        (cdb_idx),
    .cdb_iss_id     (cdb_iss_id),
    .cdb_data       (cdb_data),
    .br_resolve     (br_resolve),
    .br_mispredict  (br_mispredict),
    .retire_valid   (retire_valid),
    .retire_dest    (retire_dest),
    .retire_data    (retire_data),
    .retired_regs_o (retired_regs_o),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] reg_of(input int r);
    return retired_regs_o[(31-r)*32 +: 32];
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid   = 1'b0;
    alloc_dest    = '0;
    alloc_iss_id  = '0;
    alloc_spec    = 1'b0;
    cdb_valid     = 1'b0;
    cdb_idx       = '0;
    cdb_iss_id    = '0;
    cdb_data      = '0;
    br_resolve    = 1'b0;
    br_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    clk1();
  endtask

  task automatic alloc(input logic [4:0] d, input logic [7:0] id,
                       input logic sp);
    alloc_valid  = 1'b1;
    alloc_dest   = d;
    alloc_iss_id = id;
    alloc_spec   = sp;
    clk1();
    alloc_valid  = 1'b0;
    alloc_spec   = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] ix, input logic [7:0] id,
                     input logic [31:0] d);
    cdb_valid  = 1'b1;
    cdb_idx    = ix;
    cdb_iss_id = id;
    cdb_data   = d;
    clk1();
    cdb_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2;
    n_chk++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_empty: empty=%b count=%0d exp 1/0", empty, count);
    end
    n_chk++;
    if (alloc_ready !== 1'b1 || retire_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: rdy=%b rv=%b exp 1/00",
               alloc_ready, retire_valid);
    end
    #10;
    reset = 1'b0;
    clk1();
  endtask

  task automatic test_in_order();
    do_reset();
    n_chk++;
    if (alloc_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL io_idx0: got %0d exp 0", alloc_idx);
    end
    alloc(5'd1, 8'd10, 1'b0);
    alloc(5'd2, 8'd11, 1'b0);
    n_chk++;
    if (alloc_idx !== 4'd2) begin
      n_fail++;
      $display("FAIL io_idx2: got %0d exp 2", alloc_idx);
    end
    alloc(5'd3, 8'd12, 1'b0);
    cdb(4'd2, 8'd12, 32'hA);
    clk1();
    n_chk++;
    if (retire_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL io_wait: rv=%b exp 00", retire_valid);
    end
    cdb(4'd0, 8'd10, 32'hB);
    cdb(4'd1, 8'd11, 32'hC);
    n_chk++;
    if (retire_valid !== 2'b01 || retire_dest[4:0] !== 5'd1
        || retire_data[31:0] !== 32'hB) begin
      n_fail++;
      $display("FAIL io_first: rv=%b d=%0d v=%h exp 01/1/b",
               retire_valid, retire_dest[4:0], retire_data[31:0]);
    end
    clk1();
    n_chk++;
    if (retire_valid !== 2'b11 || retire_dest !== {5'd3, 5'd2}
        || retire_data !== {32'hA, 32'hC}) begin
      n_fail++;
      $display("FAIL io_pair: rv=%b d=%h v=%h exp 11/062/a_c",
               retire_valid, retire_dest, retire_data);
    end
    n_chk++;
    if (reg_of(1) !== 32'hB || reg_of(2) !== 32'hC
        || reg_of(3) !== 32'hA) begin
      n_fail++;
      $display("FAIL io_regs: r1=%h r2=%h r3=%h exp b c a",
               reg_of(1), reg_of(2), reg_of(3));
    end
    clk1();
    n_chk++;
    if (retire_valid !== 2'b00 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL io_drain: rv=%b empty=%b exp 00/1",
               retire_valid, empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++)
      alloc(5'd4, 8'h20 + 8'(i), 1'b0);
    n_chk++;
    if (count !== 5'd16 || full !== 1'b1 || alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: cnt=%0d full=%b rdy=%b exp 16/1/0",
               count, full, alloc_ready);
    end
    alloc(5'd9, 8'h99, 1'b0);
    n_chk++;
    if (count !== 5'd16 || alloc_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL full_17th: cnt=%0d idx=%0d exp 16/0",
               count, alloc_idx);
    end
    cdb(4'd0, 8'h20, 32'h55);
    clk1();
    n_chk++;
    if (retire_valid !== 2'b01 || count !== 5'd15
        || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL full_ret: rv=%b cnt=%0d rdy=%b idx=%0d exp 01/15/1/0",
               retire_valid, count, alloc_ready, alloc_idx);
    end
    n_chk++;
    if (reg_of(4) !== 32'h55) begin
      n_fail++;
      $display("FAIL full_reg4: got %h exp 55", reg_of(4));
    end
    alloc(5'd6, 8'h40, 1'b0);
    n_chk++;
    if (count !== 5'd16 || full !== 1'b1 || alloc_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL full_wrap: cnt=%0d full=%b idx=%0d exp 16/1/1",
               count, full, alloc_idx);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd7, 8'd1, 1'b0);
    alloc(5'd8, 8'd2, 1'b0);
    alloc(5'd9, 8'd3, 1'b1);
    alloc(5'd10, 8'd4, 1'b1);
    alloc(5'd11, 8'd5, 1'b1);
    br_resolve    = 1'b1;
    br_mispredict = 1'b1;
    alloc_valid   = 1'b1;
    alloc_dest    = 5'd20;
    alloc_iss_id  = 8'd6;
    #1;
    n_chk++;
    if (alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mp_stall: rdy=%b exp 0", alloc_ready);
    end
    clk1();
    idle();
    n_chk++;
    if (count !== 5'd2 || alloc_idx !== 4'd2) begin
      n_fail++;
      $display("FAIL mp_roll: cnt=%0d idx=%0d exp 2/2", count, alloc_idx);
    end
    cdb(4'd3, 8'd4, 32'h99);
    clk1();
    n_chk++;
    if (count !== 5'd2 || retire_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL mp_cdb: cnt=%0d rv=%b exp 2/00", count, retire_valid);
    end
    cdb(4'd0, 8'd1, 32'h31);
    cdb(4'd1, 8'd2, 32'h32);
    clk1();
    n_chk++;
    if (count !== 5'd0 || reg_of(7) !== 32'h31 || reg_of(8) !== 32'h32
        || reg_of(9) !== 32'h0) begin
      n_fail++;
      $display("FAIL mp_regs: cnt=%0d r7=%h r8=%h r9=%h exp 0/31/32/0",
               count, reg_of(7), reg_of(8), reg_of(9));
    end
    n_chk++;
    if (alloc_idx !== 4'd2) begin
      n_fail++;
      $display("FAIL mp_next: idx=%0d exp 2", alloc_idx);
    end
  endtask

  task automatic test_correct_predict();
    do_reset();
    alloc(5'd12, 8'd1, 1'b0);
    alloc(5'd13, 8'd2, 1'b0);
    alloc(5'd14, 8'd3, 1'b1);
    alloc(5'd15, 8'd4, 1'b1);
    alloc(5'd16, 8'd5, 1'b1);
    cdb(4'd2, 8'd3, 32'h102);
    cdb(4'd3, 8'd4, 32'h103);
    cdb(4'd4, 8'd5, 32'h104);
    br_resolve = 1'b1;
    clk1();
    br_resolve = 1'b0;
    n_chk++;
    if (retire_valid !== 2'b00 || count !== 5'd5) begin
      n_fail++;
      $display("FAIL cp_hold: rv=%b cnt=%0d exp 00/5", retire_valid, count);
    end
    cdb(4'd0, 8'd1, 32'h100);
    cdb(4'd1, 8'd2, 32'h101);
    n_chk++;
    if (retire_valid !== 2'b01 || retire_dest[4:0] !== 5'd12) begin
      n_fail++;
      $display("FAIL cp_r0: rv=%b d=%0d exp 01/12",
               retire_valid, retire_dest[4:0]);
    end
    clk1();
    n_chk++;
    if (retire_valid !== 2'b11 || retire_dest !== {5'd14, 5'd13}) begin
      n_fail++;
      $display("FAIL cp_r12: rv=%b d=%h exp 11/1cd",
               retire_valid, retire_dest);
    end
    clk1();
    n_chk++;
    if (retire_valid !== 2'b11 || retire_dest !== {5'd16, 5'd15}
        || retire_data !== {32'h104, 32'h103}) begin
      n_fail++;
      $display("FAIL cp_r34: rv=%b d=%h v=%h exp 11/20f/104_103",
               retire_valid, retire_dest, retire_data);
    end
    clk1();
    n_chk++;
    if (retire_valid !== 2'b00 || count !== 5'd0
        || reg_of(14) !== 32'h102 || reg_of(16) !== 32'h104) begin
      n_fail++;
      $display("FAIL cp_end: rv=%b cnt=%0d r14=%h r16=%h exp 00/0/102/104",
               retire_valid, count, reg_of(14), reg_of(16));
    end
  endtask

  task automatic test_same_dest();
    do_reset();
    alloc(5'd5, 8'd1, 1'b0);
    alloc(5'd5, 8'd2, 1'b0);
    alloc(5'd0, 8'd3, 1'b0);
    cdb(4'd1, 8'd2, 32'h22);
    cdb(4'd0, 8'd1, 32'h11);
    clk1();
    n_chk++;
    if (retire_valid !== 2'b11 || reg_of(5) !== 32'h22) begin
      n_fail++;
      $display("FAIL sd_wins: rv=%b r5=%h exp 11/22",
               retire_valid, reg_of(5));
    end
    cdb(4'd2, 8'd3, 32'h77);
    clk1();
    n_chk++;
    if (retire_valid !== 2'b01 || retire_dest[4:0] !== 5'd0
        || retire_data[31:0] !== 32'h77) begin
      n_fail++;
      $display("FAIL sd_d0: rv=%b d=%0d v=%h exp 01/0/77",
               retire_valid, retire_dest[4:0], retire_data[31:0]);
    end
    n_chk++;
    if (reg_of(0) !== 32'h0 || reg_of(5) !== 32'h22) begin
      n_fail++;
      $display("FAIL sd_r0: r0=%h r5=%h exp 0/22", reg_of(0), reg_of(5));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 7; i++)
      alloc(5'(i), 8'(i), 1'b0);
    cdb(4'd0, 8'd1, 32'h5);
    clk1();
    n_chk++;
    if (retire_valid !== 2'b01 || count !== 5'd6 || reg_of(1) !== 32'h5) begin
      n_fail++;
      $display("FAIL ar_pre: rv=%b cnt=%0d r1=%h exp 01/6/5",
               retire_valid, count, reg_of(1));
    end
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (empty !== 1'b1 || count !== 5'd0 || retire_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL ar_state: empty=%b cnt=%0d rv=%b exp 1/0/00",
               empty, count, retire_valid);
    end
    n_chk++;
    if (retired_regs_o !== '0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_regs: r1=%h rdy=%b exp 0/1", reg_of(1), alloc_ready);
    end
    #1;
    reset = 1'b0;
    clk1();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_correct_predict();
    test_same_dest();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Parametrised circular reorder buffer and in-order retirement unit. It replaces the shift-register commit stage.
- Sits between issue and the architectural register state. Issue allocates one entry per cycle in program order. Writebacks on the CDB mark entries done and capture their results.
- Up to COMMIT_W oldest done, non-speculative entries retire per cycle into an internal retired register file.
- A branch mispredict rolls the tail back to the first speculative entry in one cycle.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of 2, ≥4.
- PTR_W, 4, log2(DEPTH).
- COMMIT_W, 2, maximum retirements per cycle (1..4).
- ARCH_REGS, 32, architectural registers.
- REG_W, 5, log2(ARCH_REGS).
- ISS_W, 8, issue-id width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  issue requests an entry.
- alloc_ready  out  1  entry can be accepted this cycle.
- alloc_dest  in  REG_W  destination register; 0 means no register write.
- alloc_iss_id  in  ISS_W  issue id.
- alloc_spec  in  1  instruction is younger than an unresolved branch.
- alloc_idx  out  PTR_W  ROB index granted (equals the tail index).
- cdb_valid  in  1  writeback valid.
- cdb_idx  in  PTR_W  ROB index of the writeback.
- cdb_iss_id  in  ISS_W  issue id of the writeback; must match the stored id.
- cdb_data  in  DATA_W  result value.
- br_resolve  in  1  outstanding branch resolved this cycle.
- br_mispredict  in  1  qualifies br_resolve; 1 means mispredicted.
- retire_valid  out  COMMIT_W  per-slot retire strobe; slot 0 is oldest.
- retire_dest  out  COMMIT_W*REG_W  retired destinations.
- retire_data  out  COMMIT_W*DATA_W  retired values.
- retired_regs_o  out  ARCH_REGS*DATA_W  retired register file; register 0 is in the MSBs.
- count  out  PTR_W+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous) clears the following: head, tail, count, all entry valid/done/spec bits, the retired register file, spec_active, spec_start, and all retire_* outputs. After reset, empty=1, alloc_ready=1.
- Pointers:
  - head and tail are PTR_W+1 bits; the MSB is a wrap bit.
  - full when the index bits match and the wrap bits differ; empty when the pointers are equal.
  - Indices wrap modulo DEPTH.
- Entry fields: valid, done, spec, dest, iss_id, data.
- alloc_ready = !full && !(br_resolve && br_mispredict). The check is combinational, same cycle.
- Allocation:
  - When alloc_valid && alloc_ready, at the clock edge the entry at tail becomes valid=1, done=0, spec=alloc_spec. tail then increments.
  - alloc_idx is combinational and equals tail[PTR_W-1:0].
  - The first allocation with alloc_spec=1 while spec_active=0 records spec_start=tail and sets spec_active=1.
- Writeback:
  - If cdb_valid, the entry at cdb_idx is valid, and its stored iss_id == cdb_iss_id, then done<=1 and data<=cdb_data.
  - A mismatched or invalid target is ignored with no error.
  - A writeback to an entry being flushed in the same cycle is dropped.
- Retirement (registered outputs, 1-cycle latency from the done state):
  - Scan head, head+1, … up to COMMIT_W entries.
  - Slot k retires iff it and all older slots in the scan are valid && done && !spec, and k < count.
  - Retiring entries are cleared and head advances by the number retired.
  - dest != 0 writes retired_regs[dest] <= data. Register 0 always reads 0.
  - If two slots in one cycle share a dest, the younger slot's value wins.
- Branch resolve, correct prediction (br_resolve && !br_mispredict): clear every spec bit and spec_active. These entries may retire from the next cycle.
- Branch resolve, mispredict (br_resolve && br_mispredict):
  - Invalidate all entries with spec=1, set tail <= spec_start, clear spec_active.
  - Retirement in the same cycle still proceeds, because spec entries never retire.
  - If spec_active=0, only the alloc stall takes effect.
- count next = count + alloc_fire − retired − flushed. It never underflows, and never exceeds DEPTH.
- Full with a retirement in the same cycle: alloc_ready remains 0. The ready signal has no bypass.
- Only one unresolved branch is outstanding; issue guarantees this.

Decomposition:
- Shared include rob_defs.vh holds:
  - entry field offsets (VALID, DONE, SPEC, DEST, ISS_ID, DATA);
  - entry width localparam;
  - pointer helper macros.
- Sub-module rob_retire_select: combinational. Inputs are the COMMIT_W head-window entries plus count. Outputs are the per-slot retire mask (prefix-AND of ready) and the retire count.

Test Plan:
- Reset, then allocate dests 1,2,3; CDB completes idx2 then idx0 then idx1 with data 0xA,0xB,0xC. Expected: nothing retires until idx0 is done; idx0 retires alone. Once idx1 and idx2 are done, they retire together in one cycle (COMMIT_W=2). retired_regs[1..3] = 0xB, 0xC, 0xA.
- Fill 16 entries. Expected: full=1 and alloc_ready=0. A 17th alloc_valid is ignored. Complete idx0, it retires, and then exactly one allocation succeeds at idx0 with the wrap bit toggled.
- Allocate 2 non-speculative entries then 3 with alloc_spec=1; mispredict. Expected: tail returns to 2, count=2, the 3 entries are invalid. A later CDB to idx3 is ignored, and the next alloc_idx=2.
- Same setup with a correct prediction. Expected: spec bits clear, and all 5 entries retire in order after completion, at no more than 2 per cycle.
- Two entries with dest 5 completing with 0x11 then 0x22, retiring in the same cycle. Expected: retired_regs[5]=0x22. A dest-0 entry retires with no register-file write, and retired_regs[0]=0.
- Assert reset mid-stream with 7 entries pending. Expected: empty=1, count=0, retire_valid=0 and the register file is zero immediately, without waiting for a clock edge.
